// File: rtl/instr_loader.sv
// Boot-time program loader: receives a framed byte stream, assembles 26-bit words,
// writes them into instruction memory from address 0, and releases core reset once verified.
module instr_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned INST_W = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_data,
    output logic              mem_we,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned CAP   = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_xor;
    logic [23:0]       r_word;
    logic [CNT_W-1:0]  r_word_count;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [INST_W-1:0] r_mem_data;
    logic              r_mem_we;
    logic              r_s_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_core_rst;

    logic              w_fire;
    logic [15:0]       w_len;
    logic              w_last;
    logic              w_top_bad;
    logic              w_nxt_busy;

    assign w_fire     = s_valid && r_s_ready;
    assign w_len      = {s_data, r_len_lo};
    assign w_last     = (32'(r_word_count) + 32'd1) == 32'(r_len);
    assign w_top_bad  = |s_data[7:2];
    assign w_nxt_busy = (w_nxt == S_HDR0) || (w_nxt == S_HDR1) ||
                        (w_nxt == S_DATA) || (w_nxt == S_CHK);

    // Next-state decode; outputs are registered from the next state so they align with it.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_nxt = S_HDR0;
            end
            S_HDR0: begin
                if (w_fire) w_nxt = S_HDR1;
            end
            S_HDR1: begin
                if (w_fire) begin
                    if (w_len == 16'd0 || 32'(w_len) > CAP) w_nxt = S_ERR;
                    else                                    w_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_fire && r_byte_idx == 2'd3) begin
                    if (w_top_bad)   w_nxt = S_ERR;
                    else if (w_last) w_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (w_fire) w_nxt = (s_data == r_xor) ? S_DONE : S_ERR;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_xor        <= 8'd0;
            r_word       <= 24'd0;
            r_word_count <= '0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_we     <= 1'b0;
            r_s_ready    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst   <= 1'b1;
        end else begin
            r_state    <= w_nxt;
            r_mem_we   <= 1'b0;
            r_s_ready  <= w_nxt_busy;
            r_busy     <= w_nxt_busy;
            r_done     <= (w_nxt == S_DONE);
            r_err      <= (w_nxt == S_ERR);
            r_core_rst <= (w_nxt != S_DONE);
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_word_count <= '0;
                        r_byte_idx   <= 2'd0;
                        r_xor        <= 8'd0;
                    end
                end
                S_HDR0: begin
                    if (w_fire) r_len_lo <= s_data;
                end
                S_HDR1: begin
                    if (w_fire) r_len <= w_len;
                end
                S_DATA: begin
                    if (w_fire) begin
                        r_xor      <= r_xor ^ s_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= s_data;
                            2'd1: r_word[15:8]  <= s_data;
                            2'd2: r_word[23:16] <= s_data;
                            default: begin
                                // A word with stray upper bits is dropped, never written.
                                if (!w_top_bad) begin
                                    r_mem_we     <= 1'b1;
                                    r_mem_addr   <= r_word_count[ADDR_W-1:0];
                                    r_mem_data   <= INST_W'({s_data[1:0], r_word});
                                    r_word_count <= r_word_count + CNT_W'(1);
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign mem_we     = r_mem_we;
    assign core_rst   = r_core_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_word_count;

endmodule
